// File: rtl/matmul_pkg.sv
// matmul_pkg -- shared types for the matmul_n block.
//   state_t : controller states (IDLE, MAC, WRITE, DONE)
//   acc_w() : accumulator width wide enough to hold a full N-term dot product
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // N products of two DW-bit values need 2*DW + clog2(N) bits.
  function automatic int acc_w(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// matmul_mac_unit -- multiply-accumulate datapath for one dot product.
//   clk, rst : clock, async active-high reset
//   i_clr    : synchronous accumulator clear (wins over i_en)
//   i_en     : add i_a*i_b into the accumulator
//   i_sat    : 1 = saturate result to DW bits, 0 = keep low DW bits
//   i_a, i_b : DW-bit unsigned operands
//   o_res    : converted accumulator value (combinational from the register)
module matmul_mac_unit #(
  parameter int DW    = 8,
  parameter int ACC_W = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_sat,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_res
);

  logic [2*DW-1:0]  w_prod;
  logic [ACC_W-1:0] r_acc;
  logic             w_over;

  assign w_prod = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + ACC_W'(w_prod);
  end

  // Any bit above DW set means the sum exceeds 2^DW-1.
  assign w_over = |r_acc[ACC_W-1:DW];
  assign o_res  = (i_sat && w_over) ? {DW{1'b1}} : r_acc[DW-1:0];

endmodule

// File: rtl/matmul_n.sv
// matmul_n -- sequential N x N unsigned matrix multiply, C = A x B.
//   clk, rst      : clock, async active-high reset
//   start         : begin an operation (honoured in IDLE only)
//   sat_en        : result mode captured with start (1 = saturate, 0 = wrap)
//   mat_A, mat_B  : operands captured with start
//   mat_C         : result registers, one element written per WRITE cycle
//   busy          : high from the accepting edge until DONE is entered
//   done          : one-cycle pulse once mat_C is complete
// Each element takes N MAC cycles plus one WRITE cycle, in row-major order.
module matmul_n
  import matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           sat_en,
  input  logic [N-1:0][N-1:0][DW-1:0]    mat_A,
  input  logic [N-1:0][N-1:0][DW-1:0]    mat_B,
  output logic [N-1:0][N-1:0][DW-1:0]    mat_C,
  output logic                           busy,
  output logic                           done
);

  localparam int             ACC_W = acc_w(N, DW);
  localparam int             IW    = $clog2(N);
  localparam logic [IW-1:0]  LAST  = IW'(N - 1);

  state_t                        r_state;
  logic [N-1:0][N-1:0][DW-1:0]   r_A, r_B;
  logic                          r_sat;
  logic [IW-1:0]                 r_i, r_j, r_k;

  logic          w_accept;
  logic          w_clr;
  logic          w_en;
  logic [DW-1:0] w_res;

  assign w_accept = (r_state == S_IDLE) && start;
  // Clear on accept so the first element starts from zero, and on every
  // WRITE so the next element does too.
  assign w_clr    = w_accept || (r_state == S_WRITE);
  assign w_en     = (r_state == S_MAC);

  matmul_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_sat (r_sat),
    .i_a   (r_A[r_i][r_k]),
    .i_b   (r_B[r_k][r_j]),
    .o_res (w_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_A     <= '0;
      r_B     <= '0;
      r_sat   <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      mat_C   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_A     <= mat_A;
            r_B     <= mat_B;
            r_sat   <= sat_en;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_k == LAST) begin
            r_k     <= '0;
            r_state <= S_WRITE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_WRITE: begin
          mat_C[r_i][r_j] <= w_res;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              r_i     <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_i     <= r_i + 1'b1;
              r_state <= S_MAC;
            end
          end else begin
            r_j     <= r_j + 1'b1;
            r_state <= S_MAC;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_n.sv
// tb_matmul_n -- self-checking bench for matmul_n.
// Two instances (N=2/DW=8 and N=3/DW=4) share clock and reset. A cycle-level
// behavioural model tracks, per instance, when each element of C becomes
// visible (element e lands (e+1)*(N+1) edges after the accepting edge) and
// when busy/done change; a compare process checks every output each cycle.
// Directed scenarios add literal expectations on top.
module tb_matmul_n;

  typedef logic [1:0][1:0][7:0] m0_t;
  typedef logic [2:0][2:0][3:0] m1_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic s0_start = 1'b0, s0_sat = 1'b0, s0_busy, s0_done;
  m0_t  s0_A = '0, s0_B = '0, s0_C;
  logic s1_start = 1'b0, s1_sat = 1'b0, s1_busy, s1_done;
  m1_t  s1_A = '0, s1_B = '0, s1_C;

  int n_chk = 0;
  int n_err = 0;

  matmul_n #(.N(2), .DW(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(s0_start), .sat_en(s0_sat),
    .mat_A(s0_A), .mat_B(s0_B), .mat_C(s0_C), .busy(s0_busy), .done(s0_done));

  matmul_n #(.N(3), .DW(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .sat_en(s1_sat),
    .mat_A(s1_A), .mat_B(s1_B), .mat_C(s1_C), .busy(s1_busy), .done(s1_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_n  [2] = '{2, 3};
  int  m_dw [2] = '{8, 4};
  int  m_A  [2][3][3];
  int  m_B  [2][3][3];
  int  m_C  [2][3][3];
  bit  m_sat[2];
  bit  m_act[2];
  bit  m_done[2];
  int  m_cnt[2];

  function automatic int conv(input int s, input int dw, input bit sat);
    int mx;
    mx = (1 << dw) - 1;
    if (sat && s > mx) return mx;
    return s % (1 << dw);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int d = 0; d < 2; d++) begin
          m_act[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) m_C[d][r][c] = 0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          bit dprev, st;
          int n;
          n     = m_n[d];
          dprev = m_done[d];
          st    = (d == 0) ? s0_start : s1_start;
          m_done[d] = 0;
          if (m_act[d]) begin
            m_cnt[d]++;
            if (m_cnt[d] % (n + 1) == 0) begin
              int e, r, c, s;
              e = m_cnt[d] / (n + 1) - 1;
              r = e / n; c = e % n; s = 0;
              for (int k = 0; k < n; k++) s += m_A[d][r][k] * m_B[d][k][c];
              m_C[d][r][c] = conv(s, m_dw[d], m_sat[d]);
            end
            if (m_cnt[d] == n * n * (n + 1)) begin
              m_act[d]  = 0;
              m_done[d] = 1;
            end
          end else if (!dprev && st) begin
            m_act[d] = 1;
            m_cnt[d] = 0;
            for (int r = 0; r < n; r++)
              for (int c = 0; c < n; c++) begin
                m_A[d][r][c] = (d == 0) ? int'(s0_A[r][c]) : int'(s1_A[r][c]);
                m_B[d][r][c] = (d == 0) ? int'(s0_B[r][c]) : int'(s1_B[r][c]);
              end
            m_sat[d] = (d == 0) ? s0_sat : s1_sat;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy0", int'(s0_busy), int'(m_act[0]));
        chk("done0", int'(s0_done), int'(m_done[0]));
        chk("busy1", int'(s1_busy), int'(m_act[1]));
        chk("done1", int'(s1_done), int'(m_done[1]));
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            chk($sformatf("C0[%0d][%0d]", r, c), int'(s0_C[r][c]), m_C[0][r][c]);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            chk($sformatf("C1[%0d][%0d]", r, c), int'(s1_C[r][c]), m_C[1][r][c]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Pulse start and follow the operation. bcyc counts busy-high samples,
  // dcyc is the sample index (1 = first negedge after the accepting edge)
  // at which done was seen, 0 if never. disturb scrambles inputs while busy.
  task automatic go0(input m0_t A, input m0_t B, input bit sat, input bit disturb,
                     output int bcyc, output int dcyc);
    @(negedge clk);
    s0_A = A; s0_B = B; s0_sat = sat; s0_start = 1'b1;
    @(negedge clk);
    s0_start = 1'b0;
    bcyc = 0; dcyc = 0;
    for (int c = 1; c <= 100; c++) begin
      if (s0_busy) bcyc++;
      if (s0_done) begin dcyc = c; break; end
      if (disturb) begin
        s0_A = m0_t'({$urandom, $urandom});
        s0_B = m0_t'({$urandom, $urandom});
        s0_sat = 1'($urandom);
        s0_start = 1'($urandom);
      end
      @(negedge clk);
    end
    s0_start = 1'b0;
  endtask

  task automatic go1(input m1_t A, input m1_t B, input bit sat,
                     output int bcyc, output int dcyc);
    @(negedge clk);
    s1_A = A; s1_B = B; s1_sat = sat; s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    bcyc = 0; dcyc = 0;
    for (int c = 1; c <= 200; c++) begin
      if (s1_busy) bcyc++;
      if (s1_done) begin dcyc = c; break; end
      @(negedge clk);
    end
  endtask

  function automatic m0_t fill0(input logic [7:0] v);
    m0_t m;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) m[r][c] = v;
    return m;
  endfunction

  function automatic m1_t fill1(input logic [3:0] v);
    m1_t m;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m[r][c] = v;
    return m;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int  bc, dc, extra;
    m0_t a0, b0;

    repeat (3) @(negedge clk);
    chk("rst_busy0", int'(s0_busy), 0);
    chk("rst_done0", int'(s0_done), 0);
    chk("rst_C0", int'(s0_C == '0), 1);
    chk("rst_C1", int'(s1_C == '0), 1);
    rst = 1'b0;
    @(negedge clk);

    // all-2 x all-4 -> 16, 12 busy cycles, done after edge t0+12
    go0(fill0(8'd2), fill0(8'd4), 1'b0, 1'b0, bc, dc);
    chk("t31_busy", bc, 12);
    chk("t31_done", dc, 13);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++)
      chk("t31_C", int'(s0_C[r][c]), 16);
    @(negedge clk);
    chk("t31_done_1cyc", int'(s0_done), 0);

    // identity x B -> B
    a0 = '0; a0[0][0] = 8'd1; a0[1][1] = 8'd1;
    b0[0][0] = 8'd3; b0[0][1] = 8'd5; b0[1][0] = 8'd7; b0[1][1] = 8'd9;
    go0(a0, b0, 1'b0, 1'b0, bc, dc);
    chk("t32_C00", int'(s0_C[0][0]), 3);
    chk("t32_C01", int'(s0_C[0][1]), 5);
    chk("t32_C10", int'(s0_C[1][0]), 7);
    chk("t32_C11", int'(s0_C[1][1]), 9);

    // 80000: wrap -> 128, saturate -> 255
    go0(fill0(8'd200), fill0(8'd200), 1'b0, 1'b0, bc, dc);
    chk("t33_wrap", int'(s0_C[1][1]), 128);
    chk("t33_wrap00", int'(s0_C[0][0]), 128);
    go0(fill0(8'd200), fill0(8'd200), 1'b1, 1'b0, bc, dc);
    chk("t33_sat", int'(s0_C[1][1]), 255);
    chk("t33_sat01", int'(s0_C[0][1]), 255);

    // N=3, DW=4: 675 -> wrap 3, saturate 15, done after edge t0+36
    go1(fill1(4'd15), fill1(4'd15), 1'b0, bc, dc);
    chk("t34_busy", bc, 36);
    chk("t34_done", dc, 37);
    chk("t34_wrap", int'(s1_C[2][2]), 3);
    chk("t34_wrap01", int'(s1_C[0][1]), 3);
    go1(fill1(4'd15), fill1(4'd15), 1'b1, bc, dc);
    chk("t34_sat", int'(s1_C[2][2]), 15);
    chk("t34_sat10", int'(s1_C[1][0]), 15);

    // inputs scrambled and start re-pulsed while busy
    go0(fill0(8'd3), fill0(8'd5), 1'b0, 1'b1, bc, dc);
    chk("t35_done", dc, 13);
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++)
      chk("t35_C", int'(s0_C[r][c]), 30);
    extra = 0;
    repeat (6) begin @(negedge clk); if (s0_done) extra++; end
    chk("t35_one_done", extra, 0);

    // reset in the middle of an operation
    @(negedge clk);
    s0_A = fill0(8'd9); s0_B = fill0(8'd9); s0_start = 1'b1;
    @(negedge clk);
    s0_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t36_busy", int'(s0_busy), 0);
    chk("t36_C", int'(s0_C == '0), 1);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin @(negedge clk); if (s0_done) extra++; end
    chk("t36_no_done", extra, 0);
    go0(fill0(8'd1), fill0(8'd7), 1'b0, 1'b0, bc, dc);
    chk("t36_restart_done", dc, 13);
    chk("t36_restart_C", int'(s0_C[1][0]), 14);

    // randomized operations, checked cycle by cycle against the model
    for (int t = 0; t < 12; t++) begin
      go0(m0_t'({$urandom, $urandom}), m0_t'({$urandom, $urandom}),
          1'($urandom), 1'($urandom), bc, dc);
      chk("rnd0_done", dc, 13);
      go1(m1_t'({$urandom, $urandom, $urandom}), m1_t'({$urandom, $urandom, $urandom}),
          1'($urandom), bc, dc);
      chk("rnd1_done", dc, 37);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
